dcache_miss_fsm: RTL and testbench

Sequencing controller for the direct-mapped data cache in the MEM stage of the MIPS pipeline. It takes the load/store request and the cache's hit/dirty status. On a hit it issues the cache write strobes. On a miss it runs a write-back of the dirty victim line and then a refill from the multi-cycle main memory, holding `stall` high to freeze the pipeline until the access can complete as a hit. It also keeps a saturating miss counter for performance measurement.

---
 rtl/dcache_miss_fsm.sv | 144 ++++++++++++++
 tb/tb_dcache_miss_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_fsm.sv
// Miss sequencer for the direct-mapped MEM-stage data cache: hit strobes,
// dirty-victim write-back, multi-cycle refill, and a saturating miss counter.
module dcache_miss_fsm #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        cache_hit,
  input  logic        cache_dirty,
  input  logic        halted,
  output logic        stall,
  output logic        we_cache,
  output logic        cache_input_type,
  output logic        set_dirty,
  output logic        set_valid,
  output logic        we_memory,
  output logic        memory_address_type,
  output logic [31:0] miss_count
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   missCount_q, missCount_d;

  logic req;
  logic cntLast;

  assign req        = (mem_read | mem_write) & ~halted;
  assign cntLast    = (cnt_q == CNT_LAST);
  assign miss_count = missCount_q;

  // Hit/dirty/halt are only consulted in IDLE; a started miss always runs to DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    missCount_d = missCount_q;
    case (state_q)
      IDLE: begin
        if (req && !cache_hit) begin
          cnt_d   = '0;
          state_d = cache_dirty ? WRITEBACK : REFILL;
          if (missCount_q != 32'hFFFF_FFFF) begin
            missCount_d = missCount_q + 32'd1;
          end
        end
      end
      WRITEBACK: begin
        if (cntLast) begin
          cnt_d   = '0;
          state_d = REFILL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REFILL: begin
        if (cntLast) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      missCount_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      missCount_q <= missCount_d;
    end
  end

  // IDLE outputs are Mealy on the request; everything is forced low while in reset.
  always_comb begin
    stall               = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = 1'b0;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    we_memory           = 1'b0;
    memory_address_type = 1'b0;
    if (rst_b) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (cache_hit) begin
              if (mem_write) begin
                we_cache  = 1'b1;
                set_dirty = 1'b1;
                set_valid = 1'b1;
              end
            end else begin
              stall = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          stall               = 1'b1;
          we_memory           = 1'b1;
          memory_address_type = 1'b1;
        end
        REFILL: begin
          stall = 1'b1;
          if (cntLast) begin
            we_cache         = 1'b1;
            cache_input_type = 1'b1;
            set_valid        = 1'b1;
          end
        end
        DONE: begin
          stall = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_fsm.sv
// Directed bench for dcache_miss_fsm at MEM_LATENCY=4: hits, clean and dirty
// misses, asynchronous reset mid-miss, halt blocking and counter saturation.
module tb_dcache_miss_fsm;

  localparam int L = 4;

  // Output bundle order: stall, we_cache, cache_input_type, set_dirty,
  // set_valid, we_memory, memory_address_type
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_STALL  = 7'b1000000;
  localparam logic [6:0] O_WB     = 7'b1000011;
  localparam logic [6:0] O_REFILL = 7'b1110100;
  localparam logic [6:0] O_STHIT  = 7'b0101100;

  logic        clk;
  logic        rst_b;
  logic        mem_read;
  logic        mem_write;
  logic        cache_hit;
  logic        cache_dirty;
  logic        halted;
  logic        stall;
  logic        we_cache;
  logic        cache_input_type;
  logic        set_dirty;
  logic        set_valid;
  logic        we_memory;
  logic        memory_address_type;
  logic [31:0] miss_count;

  int checkCount = 0;
  int failCount  = 0;

  dcache_miss_fsm #(.MEM_LATENCY(L)) dut (
    .clk                 (clk),
    .rst_b               (rst_b),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .cache_hit           (cache_hit),
    .cache_dirty         (cache_dirty),
    .halted              (halted),
    .stall               (stall),
    .we_cache            (we_cache),
    .cache_input_type    (cache_input_type),
    .set_dirty           (set_dirty),
    .set_valid           (set_valid),
    .we_memory           (we_memory),
    .memory_address_type (memory_address_type),
    .miss_count          (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {25'd0, stall, we_cache, cache_input_type, set_dirty, set_valid,
            we_memory, memory_address_type};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic hit,
                               input logic dirty, input logic halt);
    mem_read    = rd;
    mem_write   = wr;
    cache_hit   = hit;
    cache_dirty = dirty;
    halted      = halt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for stall cycle c (1-based) of a miss sequence
  function automatic logic [6:0] expMiss(input bit dirty, input int c);
    int refillCycle;
    refillCycle = dirty ? (2 * L + 1) : (L + 1);
    if (dirty && c >= 2 && c <= L + 1) return O_WB;
    if (c == refillCycle) return O_REFILL;
    return O_STALL;
  endfunction

  // Walks a miss from stall cycle firstCycle to the final hit cycle; the
  // request inputs must already be applied. The line appears at DONE.
  task automatic runMiss(input string tag, input bit dirty, input bit store,
                         input int firstCycle, input logic [31:0] expCount);
    int total;
    total = dirty ? (2 * L + 2) : (L + 2);
    for (int c = firstCycle; c <= total; c++) begin
      if (c == total) begin
        cache_hit   = 1'b1;
        cache_dirty = 1'b0;
      end
      #1;
      checkOutput($sformatf("%s_cyc%0d", tag, c), outs(), {25'd0, expMiss(dirty, c)});
      nextCycle();
    end
    #1;
    checkOutput($sformatf("%s_hit", tag), outs(), {25'd0, store ? O_STHIT : O_NONE});
    checkOutput($sformatf("%s_count", tag), miss_count, expCount);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
  endtask

  initial begin
    rst_b = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    checkOutput("reset_outs", outs(), 32'd0);
    checkOutput("reset_count", miss_count, 32'd0);
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput($sformatf("idle_outs%0d", i), outs(), 32'd0);
      checkOutput($sformatf("idle_count%0d", i), miss_count, 32'd0);
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("read_hit", outs(), {25'd0, O_NONE});
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("write_hit", outs(), {25'd0, O_STHIT});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("write_hit_end", outs(), {25'd0, O_NONE});
    checkOutput("hit_count", miss_count, 32'd0);
    nextCycle();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runMiss("clean_load", 1'b0, 1'b0, 1, 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    runMiss("dirty_store", 1'b1, 1'b1, 1, 32'd2);

    // Reset lands in the second write-back cycle with the request still held
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    #1;
    checkOutput("rstmid_pre", outs(), {25'd0, O_WB});
    #1 rst_b = 1'b0;
    #1;
    checkOutput("rstmid_outs", outs(), 32'd0);
    checkOutput("rstmid_count", miss_count, 32'd0);
    #1 rst_b = 1'b1;
    runMiss("restart", 1'b1, 1'b1, 1, 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("halt_outs", outs(), 32'd0);
    nextCycle();
    checkOutput("halt_outs2", outs(), 32'd0);
    checkOutput("halt_count", miss_count, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    force dut.missCount_q = 32'hFFFF_FFFF;
    nextCycle();
    release dut.missCount_q;
    nextCycle();
    checkOutput("sat_preset", miss_count, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runMiss("sat_miss", 1'b0, 1'b0, 1, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
